alu_req_scheduler: RTL and testbench

- Shares one 4-bit combinational ALU between two requesters (port 0, port 1) using round-robin arbitration.
- Each request carries two operands and an opcode.
  - The scheduler registers the request and drives the ALU from those registers.
  - It waits a fixed settle time, captures the result and flags, and returns them on the requester's own response channel.
- Sits between the datapath masters and the ALU. Only one operation is in flight at a time.

---
 rtl/alu_req_scheduler_pkg.sv | 24 ++
 rtl/alu_req_scheduler_rr_arb2.sv | 16 +
 rtl/alu_req_scheduler.sv | 142 ++++++++++++++
 tb/tb_alu_req_scheduler.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_req_scheduler_pkg.sv
// Shared constants for the two-port ALU request scheduler: opcodes, flag bit
// positions and FSM state encodings.
package alu_req_scheduler_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_NOT = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_NEG = 3'b110;
  localparam logic [2:0] OP_SHL = 3'b111;

  // Positions within the [0:3] flag vector.
  localparam int FLG_C = 0;
  localparam int FLG_V = 1;
  localparam int FLG_Z = 2;
  localparam int FLG_N = 3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/alu_req_scheduler_rr_arb2.sv
// Two-way round-robin grant. Purely combinational; the caller owns the
// last-served pointer (0 = port 0 served last, so port 1 has priority).
module rr_arb2 (
  input  logic valid0,
  input  logic valid1,
  input  logic last_served,
  output logic gnt0,
  output logic gnt1
);

  always_comb begin
    gnt0 = valid0 && (!valid1 || last_served);
    gnt1 = valid1 && (!valid0 || !last_served);
  end

endmodule

// File: rtl/alu_req_scheduler.sv
// Shares one external combinational ALU between two requesters; one operation
// in flight at a time, fixed settle delay, per-port response handshake.
module alu_req_scheduler
  import alu_req_scheduler_pkg::*;
#(
  parameter int          WIDTH   = 4,
  parameter int          OPW     = 3,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [0:WIDTH-1] req0_a,
  input  logic [0:WIDTH-1] req0_b,
  input  logic [0:OPW-1]   req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [0:WIDTH-1] req1_a,
  input  logic [0:WIDTH-1] req1_b,
  input  logic [0:OPW-1]   req1_op,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [0:WIDTH-1] resp_data,
  output logic [0:3]       resp_flags,
  output logic [0:WIDTH-1] alu_in1,
  output logic [0:WIDTH-1] alu_in2,
  output logic [0:OPW-1]   alu_opcode,
  input  logic [0:WIDTH-1] alu_out,
  input  logic [0:3]       alu_flags,
  output logic             busy,
  output logic [7:0]       ops_count
);

  localparam logic [2:0] LAT_INIT = 3'(ALU_LAT);

  logic [1:0]       state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             owner_q, owner_d;
  logic             ptr_q, ptr_d;
  logic [0:WIDTH-1] in1_q, in1_d, in2_q, in2_d;
  logic [0:OPW-1]   op_q, op_d;
  logic [0:WIDTH-1] data_q, data_d;
  logic [0:3]       flags_q, flags_d;
  logic [7:0]       ops_q, ops_d;
  logic             gnt0, gnt1;
  logic             owner_resp_ready;

  rr_arb2 u_arb (
    .valid0      (req0_valid),
    .valid1      (req1_valid),
    .last_served (ptr_q),
    .gnt0        (gnt0),
    .gnt1        (gnt1)
  );

  assign owner_resp_ready = owner_q ? resp1_ready : resp0_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    in1_d   = in1_q;
    in2_d   = in2_q;
    op_d    = op_q;
    data_d  = data_q;
    flags_d = flags_q;
    ops_d   = ops_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt0 || gnt1) begin
          in1_d   = gnt1 ? req1_a  : req0_a;
          in2_d   = gnt1 ? req1_b  : req0_b;
          op_d    = gnt1 ? req1_op : req0_op;
          owner_d = gnt1;
          cnt_d   = LAT_INIT;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 3'd0) begin
          data_d  = alu_out;
          flags_d = alu_flags;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_RESP: begin
        // Pointer records the port just completed so the other one wins a tie.
        if (owner_resp_ready) begin
          ops_d   = ops_q + 8'd1;
          ptr_d   = owner_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      owner_q <= 1'b0;
      ptr_q   <= 1'b1;
      in1_q   <= '0;
      in2_q   <= '0;
      op_q    <= '0;
      data_q  <= '0;
      flags_q <= '0;
      ops_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      in1_q   <= in1_d;
      in2_q   <= in2_d;
      op_q    <= op_d;
      data_q  <= data_d;
      flags_q <= flags_d;
      ops_q   <= ops_d;
    end
  end

  assign req0_ready  = (state_q == ST_IDLE) && gnt0;
  assign req1_ready  = (state_q == ST_IDLE) && gnt1;
  assign resp0_valid = (state_q == ST_RESP) && !owner_q;
  assign resp1_valid = (state_q == ST_RESP) && owner_q;
  assign resp_data   = data_q;
  assign resp_flags  = flags_q;
  assign alu_in1     = in1_q;
  assign alu_in2     = in2_q;
  assign alu_opcode  = op_q;
  assign busy        = (state_q != ST_IDLE);
  assign ops_count   = ops_q;

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Bench for alu_req_scheduler: three instances (ALU_LAT 1, 0, 3) each wired to
// a behavioural ALU; instances 1 and 2 use a fixed-result ALU.
module tb_alu_req_scheduler;

  logic       clk, rst;
  logic       r0v [3], r1v [3], r0r [3], r1r [3];
  logic [0:3] r0a [3], r0b [3], r1a [3], r1b [3];
  logic [0:2] r0op[3], r1op[3];
  logic       s0v [3], s1v [3], s0r [3], s1r [3];
  logic [0:3] rd  [3], rf  [3], ai1 [3], ai2 [3], ao [3], af [3];
  logic [0:2] aop [3];
  logic       bsy [3];
  logic [7:0] opc [3];
  logic       fixed [3];

  int checks   = 0;
  int failures = 0;

  // Behavioural ALU: returns {result, carry, overflow, zero, negative}.
  function automatic logic [7:0] alu_model(logic [3:0] a, logic [3:0] b, logic [2:0] op);
    logic [4:0] s;
    logic [3:0] r;
    logic       c, v;
    c = 1'b0;
    v = 1'b0;
    s = '0;
    case (op)
      3'b000: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[3:0];
        c = s[4];
        v = (a[3] == b[3]) && (r[3] != a[3]);
      end
      3'b001: begin
        r = a - b;
        c = (a < b);
        v = (a[3] != b[3]) && (r[3] != a[3]);
      end
      3'b010: r = a & b;
      3'b011: r = a | b;
      3'b100: r = ~a;
      3'b101: r = a ^ b;
      3'b110: r = 4'd0 - a;
      default: begin
        r = {a[2:0], 1'b0};
        c = a[3];
      end
    endcase
    return {r, c, v, (r == 4'd0), r[3]};
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    alu_req_scheduler #(
      .WIDTH   (4),
      .OPW     (3),
      .ALU_LAT (gi == 0 ? 1 : (gi == 1 ? 0 : 3))
    ) u_dut (
      .clk         (clk),
      .reset       (rst),
      .req0_valid  (r0v[gi]),
      .req0_ready  (r0r[gi]),
      .req0_a      (r0a[gi]),
      .req0_b      (r0b[gi]),
      .req0_op     (r0op[gi]),
      .req1_valid  (r1v[gi]),
      .req1_ready  (r1r[gi]),
      .req1_a      (r1a[gi]),
      .req1_b      (r1b[gi]),
      .req1_op     (r1op[gi]),
      .resp0_valid (s0v[gi]),
      .resp0_ready (s0r[gi]),
      .resp1_valid (s1v[gi]),
      .resp1_ready (s1r[gi]),
      .resp_data   (rd[gi]),
      .resp_flags  (rf[gi]),
      .alu_in1     (ai1[gi]),
      .alu_in2     (ai2[gi]),
      .alu_opcode  (aop[gi]),
      .alu_out     (ao[gi]),
      .alu_flags   (af[gi]),
      .busy        (bsy[gi]),
      .ops_count   (opc[gi])
    );
    assign {ao[gi], af[gi]} = fixed[gi] ? 8'b1000_1011 : alu_model(ai1[gi], ai2[gi], aop[gi]);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic rdy(int k, int p);
    return (p != 0) ? r1r[k] : r0r[k];
  endfunction

  function automatic logic rsv(int k, int p);
    return (p != 0) ? s1v[k] : s0v[k];
  endfunction

  task automatic set_req(input int k, input int p, input logic v,
                         input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    if (p != 0) begin
      r1v[k] = v; r1a[k] = a; r1b[k] = b; r1op[k] = op;
    end else begin
      r0v[k] = v; r0a[k] = a; r0b[k] = b; r0op[k] = op;
    end
  endtask

  task automatic set_valid(input int k, input int p, input logic v);
    if (p != 0) r1v[k] = v;
    else        r0v[k] = v;
  endtask

  task automatic set_rready(input int k, input int p, input logic v);
    if (p != 0) s1r[k] = v;
    else        s0r[k] = v;
  endtask

  // Called at a negedge with port p's request already driven. Waits for the
  // accept, checks latency, result, optional backpressure hold, handshake.
  task automatic serve(input int k, input int p, input int lat, input int hold,
                       input logic [3:0] exp_a, input logic [3:0] exp_d,
                       input logic [3:0] exp_f, input int exp_ops, input string tag);
    int         n;
    logic [3:0] d0, f0;
    logic       stable, other_rdy_seen, other_resp_seen;
    other_rdy_seen  = 1'b0;
    other_resp_seen = 1'b0;
    stable          = 1'b1;
    #1;
    n = 0;
    while (!rdy(k, p) && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    if (!rdy(k, p)) begin
      chk({tag, "_accept_timeout"}, 0, 1);
      set_valid(k, p, 1'b0);
      return;
    end
    chk({tag, "_other_ready_at_grant"}, 32'(rdy(k, 1 - p)), 0);
    @(posedge clk); #1;
    set_valid(k, p, 1'b0);
    chk({tag, "_alu_in1"}, 32'(ai1[k]), 32'(exp_a));
    chk({tag, "_busy"}, 32'(bsy[k]), 1);
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (rsv(k, p)) break;
      other_resp_seen |= rsv(k, 1 - p);
      @(posedge clk);
      n++;
    end
    chk({tag, "_latency"}, n, lat + 1);
    if (!rsv(k, p)) return;
    chk({tag, "_data"}, 32'(rd[k]), 32'(exp_d));
    chk({tag, "_flags"}, 32'(rf[k]), 32'(exp_f));
    d0 = rd[k];
    f0 = rf[k];
    repeat (hold) begin
      @(posedge clk); @(negedge clk);
      stable &= rsv(k, p) && (rd[k] == d0) && (rf[k] == f0);
      other_rdy_seen  |= rdy(k, 1 - p);
      other_resp_seen |= rsv(k, 1 - p);
    end
    if (hold > 0) begin
      chk({tag, "_hold_stable"}, 32'(stable), 1);
      chk({tag, "_hold_other_ready"}, 32'(other_rdy_seen), 0);
    end
    chk({tag, "_other_resp_valid"}, 32'(other_resp_seen | rsv(k, 1 - p)), 0);
    set_rready(k, p, 1'b1);
    @(posedge clk); #1;
    set_rready(k, p, 1'b0);
    chk({tag, "_ops_count"}, 32'(opc[k]), exp_ops);
    chk({tag, "_resp_drop"}, 32'(rsv(k, p)), 0);
    @(negedge clk);
  endtask

  typedef struct {
    int         port;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
    logic [3:0] exp_d;
    logic [3:0] exp_f;   // {C,V,Z,N}
  } vec_t;

  vec_t vecs[11];
  int   hold_cnt;

  initial begin
    vecs[0]  = '{0, 4'b0011, 4'b0100, 3'b000, 4'b0111, 4'b0000};
    vecs[1]  = '{1, 4'b0111, 4'b0001, 3'b000, 4'b1000, 4'b0101};
    vecs[2]  = '{0, 4'b0011, 4'b0011, 3'b001, 4'b0000, 4'b0010};
    vecs[3]  = '{1, 4'b0001, 4'b0010, 3'b001, 4'b1111, 4'b1001};
    vecs[4]  = '{0, 4'b1100, 4'b1010, 3'b010, 4'b1000, 4'b0001};
    vecs[5]  = '{1, 4'b0101, 4'b0010, 3'b011, 4'b0111, 4'b0000};
    vecs[6]  = '{0, 4'b0101, 4'b0000, 3'b100, 4'b1010, 4'b0001};
    vecs[7]  = '{1, 4'b1111, 4'b1111, 3'b101, 4'b0000, 4'b0010};
    vecs[8]  = '{0, 4'b0001, 4'b0000, 3'b110, 4'b1111, 4'b0001};
    vecs[9]  = '{1, 4'b1001, 4'b0000, 3'b111, 4'b0010, 4'b1000};
    vecs[10] = '{0, 4'b1111, 4'b0001, 3'b000, 4'b0000, 4'b1010};

    for (int k = 0; k < 3; k++) begin
      set_req(k, 0, 1'b0, 4'd0, 4'd0, 3'd0);
      set_req(k, 1, 1'b0, 4'd0, 4'd0, 3'd0);
      s0r[k]   = 1'b0;
      s1r[k]   = 1'b0;
      fixed[k] = (k != 0);
    end

    // Reset, then five idle cycles.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset_alu_resp_bus%0d", k), 32'({ai1[k], ai2[k], aop[k], rd[k], rf[k]}), 0);
      chk($sformatf("reset_busy%0d", k), 32'(bsy[k]), 0);
      chk($sformatf("reset_ops%0d", k), 32'(opc[k]), 0);
      chk($sformatf("reset_handshake%0d", k), 32'({r0r[k], r1r[k], s0v[k], s1v[k]}), 0);
    end

    // Table: one isolated transaction per vector on the ALU_LAT=1 instance.
    for (int i = 0; i < 11; i++) begin
      set_req(0, vecs[i].port, 1'b1, vecs[i].a, vecs[i].b, vecs[i].op);
      serve(0, vecs[i].port, 1, 0, vecs[i].a, vecs[i].exp_d, vecs[i].exp_f, i + 1,
            $sformatf("vec%0d", i));
      $display("vec %0d port=%0d a=%b b=%b op=%b data=%b flags=%b", i, vecs[i].port,
               vecs[i].a, vecs[i].b, vecs[i].op, rd[0], rf[0]);
    end

    // Fresh reset so the pointer favours port 0 again.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Two simultaneous pairs: port 0, port 1, port 0, port 1.
    set_req(0, 0, 1'b1, 4'b0010, 4'b0011, 3'b000);
    set_req(0, 1, 1'b1, 4'b0101, 4'b0001, 3'b001);
    serve(0, 0, 1, 0, 4'b0010, 4'b0101, 4'b0000, 1, "arb1_p0");
    serve(0, 1, 1, 0, 4'b0101, 4'b0100, 4'b0000, 2, "arb1_p1");
    $display("arb pair1 done ops=%0d", opc[0]);
    set_req(0, 0, 1'b1, 4'b1100, 4'b0011, 3'b011);
    set_req(0, 1, 1'b1, 4'b0110, 4'b0110, 3'b101);
    serve(0, 0, 1, 0, 4'b1100, 4'b1111, 4'b0001, 3, "arb2_p0");
    serve(0, 1, 1, 0, 4'b0110, 4'b0000, 4'b0010, 4, "arb2_p1");
    $display("arb pair2 done ops=%0d", opc[0]);

    // Response backpressure on port 0 with port 1 waiting.
    hold_cnt = 6;
    set_req(0, 0, 1'b1, 4'b0100, 4'b0100, 3'b000);
    set_req(0, 1, 1'b1, 4'b0010, 4'b0000, 3'b100);
    serve(0, 0, 1, hold_cnt, 4'b0100, 4'b1000, 4'b0101, 5, "bp_p0");
    chk("bp_p1_ready_after_handshake", 32'(r1r[0]), 1);
    serve(0, 1, 1, 0, 4'b0010, 4'b1101, 4'b0001, 6, "bp_p1");
    $display("backpressure done ops=%0d", opc[0]);

    // Latency extremes with a fixed-result ALU.
    set_req(1, 0, 1'b1, 4'b0011, 4'b0001, 3'b000);
    serve(1, 0, 0, 0, 4'b0011, 4'b1000, 4'b1011, 1, "lat0");
    $display("lat0 data=%b flags=%b", rd[1], rf[1]);
    set_req(2, 1, 1'b1, 4'b0110, 4'b0001, 3'b010);
    serve(2, 1, 3, 0, 4'b0110, 4'b1000, 4'b1011, 1, "lat3");
    $display("lat3 data=%b flags=%b", rd[2], rf[2]);

    // Asynchronous reset in the middle of a WAIT on the ALU_LAT=3 instance.
    set_req(2, 0, 1'b1, 4'b1010, 4'b0101, 3'b011);
    #1;
    chk("midwait_accept_ready", 32'(r0r[2]), 1);
    @(posedge clk); #1;
    set_valid(2, 0, 1'b0);
    @(posedge clk); #3;
    chk("midwait_busy_before", 32'(bsy[2]), 1);
    rst = 1'b1;
    #1;
    chk("midwait_busy_async", 32'(bsy[2]), 0);
    chk("midwait_alu_async", 32'({ai1[2], ai2[2], aop[2]}), 0);
    chk("midwait_ops_async", 32'(opc[2]), 0);
    @(negedge clk);
    rst = 1'b0;
    hold_cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (s0v[2] || s1v[2] || bsy[2]) hold_cnt++;
    end
    chk("midwait_no_resp_after", hold_cnt, 0);
    chk("midwait_ops_after", 32'(opc[2]), 0);
    $display("midwait reset done busy=%0d ops=%0d", bsy[2], opc[2]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
